// File: rtl/scaled_adder.sv
// Signed adder with arithmetic right-shift scaling, width reduction and one output register.
// Optional build macro SCALED_ADDER_SATURATE_EN: the reduce stage saturates instead of wrapping.
module scaled_adder #(
  parameter int a_width   = 30,
  parameter int b_width   = 14,
  parameter int out_width = 15,
  parameter int out_scale = 20
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        in_valid,
  input  logic signed [a_width-1:0]   a,
  input  logic signed [b_width-1:0]   b,
  output logic                        out_valid,
  output logic signed [out_width-1:0] out
);

  // One guard bit above the wider operand means the sum can never overflow.
  localparam int sum_width = ((a_width > b_width) ? a_width : b_width) + 1;

  logic signed [sum_width-1:0] a_ext;
  logic signed [sum_width-1:0] b_ext;
  logic signed [sum_width-1:0] sum;
  logic signed [sum_width-1:0] scaled;
  logic signed [out_width-1:0] reduced;

  logic signed [out_width-1:0] out_d;
  logic signed [out_width-1:0] out_q;
  logic                        valid_d;
  logic                        valid_q;

  assign a_ext = sum_width'(a);
  assign b_ext = sum_width'(b);
  assign sum   = a_ext + b_ext;

  // Arithmetic shift floors toward -inf; shifts >= sum_width leave only sign bits (0 or -1).
  assign scaled = sum >>> out_scale;

`ifdef SCALED_ADDER_SATURATE_EN
  generate
    if (out_width >= sum_width) begin : g_no_clip
      assign reduced = out_width'(scaled);
    end else begin : g_clip
      localparam logic signed [sum_width-1:0] sat_max =
        {{(sum_width-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
      localparam logic signed [sum_width-1:0] sat_min =
        {{(sum_width-out_width+1){1'b1}}, {(out_width-1){1'b0}}};

      always_comb begin
        // NOTE: assign a default first so every path writes reduced and no latch is inferred.
        reduced = out_width'(scaled);
        if (scaled > sat_max) begin
          reduced = {1'b0, {(out_width-1){1'b1}}};
        end else if (scaled < sat_min) begin
          reduced = {1'b1, {(out_width-1){1'b0}}};
        end
      end
    end
  endgenerate
`else
  // A size cast of a signed value truncates when narrowing and sign-extends when widening.
  assign reduced = out_width'(scaled);
`endif

  // Operands are only looked at in a valid cycle, so idle-cycle X on a/b never reaches out.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    if (in_valid) begin
      out_d   = reduced;
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_scaled_adder.sv
// Scoreboard bench for scaled_adder: default instance plus an out_width=8 instance on shared inputs.
module tb_scaled_adder;

  localparam int  A_W   = 30;
  localparam int  B_W   = 14;
  localparam int  SCALE = 20;
`ifdef SCALED_ADDER_SATURATE_EN
  localparam bit  SAT   = 1'b1;
`else
  localparam bit  SAT   = 1'b0;
`endif

  typedef struct {
    int     due;
    bit     v;
    longint e15;
    longint e8;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   arst;
  logic                   in_valid;
  logic signed [A_W-1:0]  a;
  logic signed [B_W-1:0]  b;
  logic                   ov15, ov8;
  logic signed [14:0]     out15;
  logic signed [7:0]      out8;

  exp_t   sb[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_err = 0;
  longint last15 = 0;
  longint last8 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scaled_adder #(.a_width(A_W), .b_width(B_W), .out_width(15), .out_scale(SCALE)) dut15 (
    .clk(clk), .arst(arst), .in_valid(in_valid), .a(a), .b(b), .out_valid(ov15), .out(out15)
  );

  scaled_adder #(.a_width(A_W), .b_width(B_W), .out_width(8), .out_scale(SCALE)) dut8 (
    .clk(clk), .arst(arst), .in_valid(in_valid), .a(a), .b(b), .out_valid(ov8), .out(out8)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact integer sum, floor division by 2^SCALE, then wrap modulo 2^w or clamp.
  function automatic longint model(input longint av, input longint bv, input int w);
    longint s, q, lim, m;
    s   = av + bv;
    q   = s >>> SCALE;
    lim = 64'sd1 <<< (w - 1);
    if (SAT) begin
      if (q > lim - 1) return lim - 1;
      if (q < -lim) return -lim;
      return q;
    end
    m = q % (2 * lim);
    if (m < 0) m += 2 * lim;
    if (m >= lim) m -= 2 * lim;
    return m;
  endfunction

  // Drives one cycle of stimulus (called just after a rising edge) and records its expectation.
  task automatic issue(input bit v, input longint av, input longint bv,
                       input longint e15, input longint e8);
    exp_t e;
    in_valid = v;
    a = A_W'(av);
    b = B_W'(bv);
    if (v) begin
      last15 = e15;
      last8  = e8;
    end
    e.due = cyc + 1;
    e.v   = v;
    e.e15 = last15;
    e.e8  = last8;
    sb.push_back(e);
  endtask

  task automatic issue_model(input bit v, input longint av, input longint bv);
    issue(v, av, bv, model(av, bv, 15), model(av, bv, 8));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever a result is due, compare both instances against the queued expectation.
  always @(negedge clk) begin
    if (!arst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        void'(sb.pop_front());
        check("missed_slot", 0, 1);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("valid15", longint'(ov15), longint'(e.v));
        check("valid8",  longint'(ov8),  longint'(e.v));
        check("out15",   longint'(out15), e.e15);
        check("out8",    longint'(out8),  e.e8);
      end
    end
  end

  initial begin
    longint amax, amin, bmax, bmin;
    amax = (64'sd1 <<< (A_W - 1)) - 1;
    amin = -(64'sd1 <<< (A_W - 1));
    bmax = (64'sd1 <<< (B_W - 1)) - 1;
    bmin = -(64'sd1 <<< (B_W - 1));

    arst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    #2;
    check("rst_out15",   longint'(out15), 0);
    check("rst_valid15", longint'(ov15), 0);
    check("rst_out8",    longint'(out8), 0);
    check("rst_valid8",  longint'(ov8), 0);
    #20;
    arst = 1'b0;
    next_cycle();

    // Traffic, then a reset pulse between edges that must clear outputs and drop the pending result.
    issue(1, amax, bmax, 512, SAT ? 127 : 0);
    next_cycle();
    issue(1, 64'h155555, 5, model(64'h155555, 5, 15), model(64'h155555, 5, 8));
    #1;
    arst = 1'b1;
    #1;
    check("async_out15",   longint'(out15), 0);
    check("async_valid15", longint'(ov15), 0);
    check("async_out8",    longint'(out8), 0);
    check("async_valid8",  longint'(ov8), 0);
    sb.delete();
    last15 = 0;
    last8  = 0;
    #1;
    arst = 1'b0;
    issue(1, 64'h100000, 0, 1, 1);
    next_cycle();

    // Floor semantics and rounding boundaries.
    issue(1, -1, 0, -1, -1);
    next_cycle();
    issue(1, 64'h0FFFFF, 0, 0, 0);
    next_cycle();
    issue(1, 64'h0FFFFF, 1, 1, 1);
    next_cycle();
    issue(0, 0, 0, 0, 0);
    next_cycle();
    // Extreme operands: 15-bit result fits, 8-bit result wraps or saturates.
    issue(1, amax, bmax, 512, SAT ? 127 : 0);
    next_cycle();
    issue(1, amin, bmin, -513, SAT ? -128 : -1);
    next_cycle();
    issue(0, amax, bmax, 0, 0);
    next_cycle();

    // Random back-to-back traffic with gaps and occasional extreme operands.
    for (int i = 0; i < 10000; i++) begin
      longint av, bv;
      bit     v;
      v  = ($urandom_range(3) != 0);
      av = longint'($signed(A_W'($urandom)));
      bv = longint'($signed(B_W'($urandom)));
      case ($urandom_range(7))
        0: av = amax;
        1: av = amin;
        2: bv = bmax;
        3: bv = bmin;
        default: ;
      endcase
      issue_model(v, av, bv);
      next_cycle();
    end
    in_valid = 1'b0;

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) check("drain_timeout", longint'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
